// File: rtl/ram_arbiter.sv
// Shares the single-port ram4k block between the CPU and a secondary bus master (DMA / boot loader).
// The CPU is stalled through RDY while the DMA owns the RAM, and DMA bursts are bounded to guarantee CPU slots.
module ram_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              res,
   input  logic              cpu_sel,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rdy,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {
      CPU_OWN,
      DMA_OWN
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic             slot_hold, slot_hold_nxt;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= CPU_OWN;
         burst_cnt <= '0;
         slot_hold <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         slot_hold <= slot_hold_nxt;
      end
   end

   // slot_hold marks the first CPU_OWN cycle after a DMA tenure; DMA may not be
   // re-entered from that cycle, so the CPU always gets a full access slot.
   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      slot_hold_nxt = slot_hold;
      ram_addr      = cpu_addr;
      ram_wdata     = cpu_wdata;
      ram_we        = cpu_we & cpu_sel;
      cpu_rdy       = 1'b1;
      dma_ack       = 1'b0;

      case (state)
         CPU_OWN: begin
            if (slot_hold) begin
               slot_hold_nxt = 1'b0;
            end else if (dma_req) begin
               state_nxt     = DMA_OWN;
               burst_cnt_nxt = '0;
            end
         end

         DMA_OWN: begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we & dma_req;
            cpu_rdy   = 1'b0;
            dma_ack   = dma_req;
            if (!dma_req) begin
               state_nxt     = CPU_OWN;
               slot_hold_nxt = 1'b1;
            end else if (burst_cnt == LAST_CNT) begin
               state_nxt     = CPU_OWN;
               burst_cnt_nxt = '0;
               slot_hold_nxt = 1'b1;
            end else begin
               burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = CPU_OWN;
         end
      endcase
   end

   // Read-valid strobes line up with the one-cycle registered RAM read.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= (state == CPU_OWN) && cpu_sel && !cpu_we;
         dma_rvalid <= dma_ack && !dma_we;
      end
   end

   assign dma_rdata = ram_rdata;

   a_cnt_bound : assert property (@(posedge clk) disable iff (!res) burst_cnt <= LAST_CNT);
   a_exclusive : assert property (@(posedge clk) disable iff (!res) !(cpu_rdy && dma_ack));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a ram4k-style memory model; read data is
// checked by a monitor popping expected words from per-master scoreboards.
module tb_ram_arbiter;

   logic        clk;
   logic        res;
   logic        cpu_sel, cpu_we;
   logic [11:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_rdy, cpu_rvalid;
   logic        dma_req, dma_we;
   logic [11:0] dma_addr;
   logic [15:0] dma_wdata;
   logic        dma_ack, dma_rvalid;
   logic [15:0] dma_rdata;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   logic [15:0] mem [0:4095];
   logic [15:0] cpu_exp [$];
   logic [15:0] dma_exp [$];
   logic [15:0] exp_word;
   int          n_checks = 0;
   int          n_errors = 0;

   ram_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_BURST(4)) dut (
      .clk        (clk),
      .res        (res),
      .cpu_sel    (cpu_sel),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdy    (cpu_rdy),
      .cpu_rvalid (cpu_rvalid),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_ack    (dma_ack),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ram4k model: write-first is not assumed, read returns the pre-write word.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One clock cycle of stimulus: inputs change just after the edge, outputs are sampled at the falling edge.
   task automatic applyStimulus(input logic rs, input logic sel, input logic we, input logic [11:0] addr,
                                input logic [15:0] wd, input logic dreq, input logic dwe,
                                input logic [11:0] daddr, input logic [15:0] dwd);
      @(posedge clk);
      #1;
      res       = rs;
      cpu_sel   = sel;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      dma_req   = dreq;
      dma_we    = dwe;
      dma_addr  = daddr;
      dma_wdata = dwd;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
   endtask

   // Scoreboard monitor: every read strobe must match the next queued word.
   always @(negedge clk) begin
      if (res) begin
         if (cpu_rvalid) begin
            if (cpu_exp.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL cpu_rvalid: got 1 with nothing outstanding, expected 0");
            end else begin
               exp_word = cpu_exp.pop_front();
               checkOutput("cpu_read_data", 32'(ram_rdata), 32'(exp_word));
            end
         end
         if (dma_rvalid) begin
            if (dma_exp.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL dma_rvalid: got 1 with nothing outstanding, expected 0");
            end else begin
               exp_word = dma_exp.pop_front();
               checkOutput("dma_read_data", 32'(dma_rdata), 32'(exp_word));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ack_pat;
      logic [15:0] rdy_pat;
      int          idx;

      // Reset with a DMA write request already held.
      res       = 1'b0;
      cpu_sel   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 12'h000;
      cpu_wdata = 16'h0000;
      dma_req   = 1'b1;
      dma_we    = 1'b1;
      dma_addr  = 12'h020;
      dma_wdata = 16'hA5A5;
      repeat (3) @(negedge clk);
      checkOutput("reset_cpu_rdy", 32'(cpu_rdy), 32'd1);
      checkOutput("reset_dma_ack", 32'(dma_ack), 32'd0);
      checkOutput("reset_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("reset_dma_rvalid", 32'(dma_rvalid), 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'hA5A5);
      checkOutput("post_reset_c1_ack", 32'(dma_ack), 32'd0);
      checkOutput("post_reset_c1_rdy", 32'(cpu_rdy), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'hA5A5);
      checkOutput("post_reset_c2_ack", 32'(dma_ack), 32'd1);
      checkOutput("post_reset_c2_ram_we", 32'(ram_we), 32'd1);
      checkOutput("post_reset_c2_ram_addr", 32'(ram_addr), 32'h020);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h020, 16'hA5A5);
      checkOutput("req_drop_ack", 32'(dma_ack), 32'd0);
      checkOutput("req_drop_rdy", 32'(cpu_rdy), 32'd0);
      idle();
      checkOutput("after_drop_rdy", 32'(cpu_rdy), 32'd1);

      // CPU-only writes and reads.
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h010, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000);
      checkOutput("cpu_wr_ram_we", 32'(ram_we), 32'd1);
      checkOutput("cpu_wr_ram_wdata", 32'(ram_wdata), 32'h1234);
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      checkOutput("cpu_rd_ram_we", 32'(ram_we), 32'd0);
      cpu_exp.push_back(16'h1234);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h000, 16'h0F0F, 1'b0, 1'b0, 12'h000, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h7FF, 16'hBEEF, 1'b0, 1'b0, 12'h000, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      cpu_exp.push_back(16'hA5A5);
      idle();
      checkOutput("idle_ram_we", 32'(ram_we), 32'd0);

      // Simultaneous CPU read and DMA read request: CPU first, then DMA.
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h7FF, 16'h0000);
      checkOutput("simul_cpu_rdy", 32'(cpu_rdy), 32'd1);
      checkOutput("simul_dma_ack", 32'(dma_ack), 32'd0);
      cpu_exp.push_back(16'h0F0F);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h7FF, 16'h0000);
      checkOutput("dma_rd_ack", 32'(dma_ack), 32'd1);
      checkOutput("dma_rd_rdy", 32'(cpu_rdy), 32'd0);
      checkOutput("dma_rd_ram_addr", 32'(ram_addr), 32'h7FF);
      dma_exp.push_back(16'hBEEF);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      checkOutput("dma_rd_done_ack", 32'(dma_ack), 32'd0);
      idle();
      idle();

      // Ten-word DMA write burst with MAX_BURST = 4.
      ack_pat = 16'b0110_0111_1001_1110;
      rdy_pat = 16'b0001_1000_0110_0001;
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, (idx < 10) ? 1'b1 : 1'b0, 1'b1,
                       12'h100 + 12'(idx), 16'hD000 + 16'(idx));
         checkOutput($sformatf("burst_ack_c%0d", c), 32'(dma_ack), 32'(ack_pat[c]));
         checkOutput($sformatf("burst_rdy_c%0d", c), 32'(cpu_rdy), 32'(rdy_pat[c]));
         if (dma_ack) idx++;
      end
      checkOutput("burst_words_acked", 32'(idx), 32'd10);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 12'h100 + 12'(i), 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
         cpu_exp.push_back(16'hD000 + 16'(i));
      end
      idle();
      idle();

      // DMA and a stalled CPU write to the same word: the held CPU write lands last.
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h200, 16'hDDDD);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h200, 16'hCCCC, 1'b1, 1'b1, 12'h200, 16'hDDDD);
      checkOutput("coll_dma_rdy", 32'(cpu_rdy), 32'd0);
      checkOutput("coll_dma_ram_we", 32'(ram_we), 32'd1);
      checkOutput("coll_dma_wdata", 32'(ram_wdata), 32'hDDDD);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h200, 16'hCCCC, 1'b0, 1'b0, 12'h000, 16'h0000);
      checkOutput("coll_hold_rdy", 32'(cpu_rdy), 32'd0);
      checkOutput("coll_hold_ram_we", 32'(ram_we), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h200, 16'hCCCC, 1'b0, 1'b0, 12'h000, 16'h0000);
      checkOutput("coll_cpu_rdy", 32'(cpu_rdy), 32'd1);
      checkOutput("coll_cpu_wdata", 32'(ram_wdata), 32'hCCCC);
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h200, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      cpu_exp.push_back(16'hCCCC);
      idle();
      idle();

      // Reset pulse in the second cycle of a DMA burst.
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h100, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h100, 16'h0000);
      checkOutput("midburst_ack", 32'(dma_ack), 32'd1);
      for (int r = 0; r < 2; r++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h300, 16'hEEEE);
         checkOutput($sformatf("rst%0d_rdy", r), 32'(cpu_rdy), 32'd1);
         checkOutput($sformatf("rst%0d_ack", r), 32'(dma_ack), 32'd0);
         checkOutput($sformatf("rst%0d_dma_rvalid", r), 32'(dma_rvalid), 32'd0);
         checkOutput($sformatf("rst%0d_ram_we", r), 32'(ram_we), 32'd0);
      end
      idle();
      checkOutput("rst_exit_c1_ack", 32'(dma_ack), 32'd0);
      checkOutput("rst_exit_c1_rdy", 32'(cpu_rdy), 32'd1);
      idle();
      checkOutput("rst_exit_c2_rdy", 32'(cpu_rdy), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h300, 16'hEEEE);
      checkOutput("rereq_c1_ack", 32'(dma_ack), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h300, 16'hEEEE);
      checkOutput("rereq_c2_ack", 32'(dma_ack), 32'd1);
      checkOutput("rereq_c2_ram_we", 32'(ram_we), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 12'h300, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
      cpu_exp.push_back(16'hEEEE);
      idle();
      idle();
      idle();

      checkOutput("cpu_reads_outstanding", 32'(cpu_exp.size()), 32'd0);
      checkOutput("dma_reads_outstanding", 32'(dma_exp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single on-chip block RAM (ram4k, 1-cycle registered read) between the 65Org16 CPU and a secondary bus master, such as an i2c boot loader or DMA engine. It sits between the CPU/DMA address, data and write lines and the RAM port. It stalls the CPU through its RDY input while the DMA master owns the RAM. It bounds DMA bursts so the CPU always gets a slot, and it generates per-master read-data-valid strobes that match the RAM pipeline latency.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 16, data width (`bytesize)
- MAX_BURST, 4, maximum consecutive DMA accesses before a forced CPU slot (1..15)

Ports:
- clk  in  1  system clock, all logic on posedge
- res  in  1  reset; asynchronous and active-low
- cpu_sel  in  1  CPU address decodes to RAM this cycle
- cpu_we  in  1  CPU write strobe
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdy  out  1  to CPU RDY; 0 = CPU stalled, must hold AB/DO/WE
- cpu_rvalid  out  1  ram_rdata is valid CPU read data this cycle
- dma_req  in  1  DMA access request; held with addr/we/wdata until acked
- dma_we  in  1  DMA write strobe
- dma_addr  in  ADDR_W  DMA word address
- dma_wdata  in  DATA_W  DMA write data
- dma_ack  out  1  DMA access performed this cycle
- dma_rvalid  out  1  dma_rdata valid (cycle after a read ack)
- dma_rdata  out  DATA_W  DMA read data (= ram_rdata)
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address (used as both Waddr and Raddr)
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM registered read data

## Operation
- States: CPU_OWN, DMA_OWN. Reset state is CPU_OWN. Burst counter is ceil(log2(MAX_BURST+1)) bits, reset 0.
- CPU_OWN:
  - ram_addr/ram_wdata come from the CPU; ram_we = cpu_we & cpu_sel.
  - cpu_rdy = 1; dma_ack = 0.
  - If dma_req = 1 at a clock edge, next state is DMA_OWN and the counter is cleared.
- DMA_OWN:
  - ram_addr/ram_wdata come from the DMA; ram_we = dma_we & dma_req.
  - cpu_rdy = 0 regardless of cpu_sel. Any CPU write is suppressed.
  - dma_ack = dma_req (combinational).
  - Each ack increments the counter.
  - Exit to CPU_OWN at the edge where dma_req = 0, or where an ack occurs with counter = MAX_BURST-1.
- Guaranteed CPU slot: after leaving DMA_OWN, the arbiter spends at least one cycle in CPU_OWN, even with dma_req still high. DMA is re-entered on the following edge.
- Read strobes, registered:
  - cpu_rvalid <= (state==CPU_OWN) & cpu_sel & ~cpu_we
  - dma_rvalid <= dma_ack & ~dma_we
- dma_rdata is ram_rdata passed straight through. The CPU data mux uses cpu_rvalid in place of the top-level ram-valid flop.
- DMA writes and reads are word-wide. There are no byte enables.

## Timing
- Reset values: state CPU_OWN, counter 0, cpu_rdy 1, dma_ack 0, cpu_rvalid 0, dma_rvalid 0. While in CPU_OWN with cpu_sel = 0, ram_we is 0.
- DMA latency:
  - First dma_req assertion at edge N: ack is in cycle N+1.
  - Read data: dma_rvalid is high in cycle N+2.
- Burst of K ≥ MAX_BURST requests:
  - MAX_BURST acks, then 1 CPU cycle, then 1 DMA-entry edge, repeating.
  - CPU sees at most MAX_BURST stall cycles in a row.
- The stall is combinational from state. cpu_rdy changes only after clock edges, never from DMA inputs within a cycle.
- Simultaneous cpu_sel and dma_req in CPU_OWN: the CPU access completes that cycle, and DMA owns the next.
- If dma_req drops in DMA_OWN, there is no ack that cycle and the state returns to CPU_OWN next edge.
- Reset asserted mid-burst:
  - State returns immediately to CPU_OWN and the rvalid flops clear.
  - An un-acked DMA request is dropped; the DMA master must re-issue after reset.
- Counter never exceeds MAX_BURST-1; no wrap.

## Test plan
- Reset with dma_req=1 held → cpu_rdy=1, dma_ack=0, rvalid both 0 during reset. First ack is in the 2nd cycle after res deasserts.
- CPU write 0x1234 to 0x010, then read 0x010, no DMA → ram_we for 1 cycle; cpu_rvalid=1 the cycle after the read, with ram_rdata=0x1234.
- DMA single read of 0x7FF (preloaded 0xBEEF) while CPU reads 0x000 → CPU access that cycle; then dma_ack, cpu_rdy=0; dma_rvalid next cycle with dma_rdata=0xBEEF.
- dma_req held for 10 writes, MAX_BURST=4 → ack pattern 4 on, 1 off, 1 off, 4 on, ... cpu_rdy low at most 4 consecutive cycles; all 10 words land correctly.
- DMA write while CPU presents a write to the same address → DMA data wins in DMA_OWN. The CPU write is held under cpu_rdy=0 and lands in the first CPU_OWN cycle, so the final value is the CPU data.
- Reset pulse in the 2nd cycle of a DMA burst → state returns to CPU_OWN, dma_rvalid=0, no ram_we during reset, and DMA resumes only on re-request.
